muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit; sits directly downstream of the register file read ports.
- Consumes the two source operands (rs1 value, rs2 value) plus the destination register index.
- Produces a result and a one-cycle write-back strobe that drives the register file write port (rwdata/rd/RegWrite).
- Holds busy high while computing so the core stalls issue.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between issue logic and the RV32M multiply/divide unit.
// master = issuing core side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wb_en;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, wb_en
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, wb_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle over IDLE -> PREP -> CALC (ITERS cycles) -> FIN.
// Optional macro MULDIV_EARLY_OUT_EN: special cases (divide by zero, DIV
// overflow, zero operand) skip CALC and complete two edges after start.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(ITERS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;
  state_t state_reg, state_next;

  logic [2:0]        f3_reg;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [4:0]        rd_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, mcand_reg;
  logic [CW-1:0]     cnt_reg;
  logic              neg_res_reg, neg_rem_reg, div_zero_reg, ovf_reg, zero_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        rd_out_reg;

  logic              is_div;
  logic              signed_a, signed_b, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero_pre, ovf_pre, zero_pre, early_out;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s, r_s, fin_val;

  assign is_div = f3_reg[2];

  // Operand sign handling and special-case detection, consumed in PREP
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (f3_reg)
      3'd1, 3'd4, 3'd6: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'd2:             signed_a = 1'b1;
      default:          ;
    endcase
    sa           = signed_a & a_reg[XLEN-1];
    sb           = signed_b & b_reg[XLEN-1];
    mag_a        = sa ? (~a_reg + 1'b1) : a_reg;
    mag_b        = sb ? (~b_reg + 1'b1) : b_reg;
    div_zero_pre = is_div & (b_reg == '0);
    ovf_pre      = is_div & ~f3_reg[0] & (a_reg == MIN_NEG) & (&b_reg);
    zero_pre     = ((a_reg == '0) | (b_reg == '0)) & ~div_zero_pre;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = div_zero_pre | ovf_pre | zero_pre;
`else
  assign early_out = 1'b0;
`endif

  // One iteration step: multiply adds-then-shifts, divide shifts-then-subtracts
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mcand_reg});
    div_diff  = div_shift - {1'b0, mcand_reg};
  end

  // Final sign fix-up and result selection, with special cases forced
  always_comb begin
    prod_s  = neg_res_reg ? (~{hi_reg, lo_reg} + 1'b1) : {hi_reg, lo_reg};
    q_s     = neg_res_reg ? (~lo_reg + 1'b1) : lo_reg;
    r_s     = neg_rem_reg ? (~hi_reg + 1'b1) : hi_reg;
    fin_val = '0;
    case (f3_reg)
      3'd0:             fin_val = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_val = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin_val = div_zero_reg ? '1 : (ovf_reg ? MIN_NEG : q_s);
      default:          fin_val = div_zero_reg ? a_reg : (ovf_reg ? '0 : r_s);
    endcase
    if (zero_reg) fin_val = '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; flush aborts any non-idle state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start && !bus.flush) state_next = PREP;
      PREP: if (bus.flush)      state_next = IDLE;
            else if (early_out) state_next = FIN;
            else                state_next = CALC;
      CALC: if (bus.flush)                      state_next = IDLE;
            else if (cnt_reg == CW'(ITERS - 1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      rd_reg       <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      mcand_reg    <= '0;
      cnt_reg      <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      rd_out_reg   <= '0;
    end else begin
      done_reg <= (state_reg == FIN) && !bus.flush;
      case (state_reg)
        IDLE: if (bus.start && !bus.flush) begin
          f3_reg <= bus.funct3;
          a_reg  <= bus.op_a;
          b_reg  <= bus.op_b;
          rd_reg <= bus.rd_in;
        end
        PREP: begin
          hi_reg       <= '0;
          lo_reg       <= is_div ? mag_a : mag_b;
          mcand_reg    <= is_div ? mag_b : mag_a;
          cnt_reg      <= '0;
          neg_res_reg  <= sa ^ sb;
          neg_rem_reg  <= sa;
          div_zero_reg <= div_zero_pre;
          ovf_reg      <= ovf_pre;
          zero_reg     <= zero_pre;
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div) begin
            hi_reg <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_reg <= {lo_reg[XLEN-2:0], div_ge};
          end else begin
            hi_reg <= mul_sum[XLEN:1];
            lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
          end
        end
        FIN: if (!bus.flush) begin
          result_reg <= fin_val;
          rd_out_reg <= rd_reg;
        end
        default: ;
      endcase
    end
  end

  // Outputs; busy also covers the done cycle, and a start may be taken on the
  // edge that closes it since the FSM is already back in IDLE
  always_comb begin
    bus.busy   = (state_reg != IDLE) || done_reg;
    bus.done   = done_reg;
    bus.wb_en  = done_reg && (rd_out_reg != 5'd0);
    bus.result = result_reg;
    bus.rd_out = rd_out_reg;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: multiply, divide, special cases,
// flush, ignored start, mid-operation reset, rd=0 and back-to-back issue.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 34;
`endif

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op now (before the next rising edge) and wait for done.
  // lat counts edges after the sampling edge; -1 means timeout.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output logic wb, output logic bz, output int lat);
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    lat = -1;
    res = 32'hDEADBEEF;
    rdo = 5'h1F;
    wb  = 1'bx;
    bz  = 1'bx;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        rdo = bus.rd_out;
        wb  = bus.wb_en;
        bz  = bus.busy;
        break;
      end
    end
    $display("op f3=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d wb_en=%b lat=%0d",
             f3, a, b, rd, res, rdo, wb, lat);
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.wb_en !== 1'b0)   begin bad++; $display("FAIL reset_wb_en got=%b want=0", bus.wb_en); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.rd_out !== 5'h0)  begin bad++; $display("FAIL reset_rd_out got=%h want=0", bus.rd_out); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL post_reset_busy got=%b want=0", bus.busy); end
    $display("reset done");
  endtask

  task automatic test_mul;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, res, rdo, wb, bz, lat);
    total++; if (lat !== 34)           begin bad++; $display("FAIL mul_latency got=%0d want=34", lat); end
    total++; if (res !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h want=ffffffeb", res); end
    total++; if (wb !== 1'b1)          begin bad++; $display("FAIL mul_wb_en got=%b want=1", wb); end
    total++; if (rdo !== 5'd5)         begin bad++; $display("FAIL mul_rd_out got=%0d want=5", rdo); end
    total++; if (bz !== 1'b1)          begin bad++; $display("FAIL mul_busy_in_done got=%b want=1", bz); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL mul_done_pulse got=%b want=0", bus.done); end
    total++; if (bus.wb_en !== 1'b0)   begin bad++; $display("FAIL mul_wb_pulse got=%b want=0", bus.wb_en); end
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL mul_busy_after got=%b want=0", bus.busy); end
    total++; if (bus.result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result_hold got=%h want=ffffffeb", bus.result); end
  endtask

  task automatic test_mulh;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    logic [2:0] f3; logic [31:0] a, b, exp;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin f3 = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; exp = 32'hFFFFFFFE; end
        1: begin f3 = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; exp = 32'h00000000; end
        2: begin f3 = 3'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; exp = 32'hFFFFFFFF; end
        default: begin f3 = 3'd0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; exp = 32'h00000001; end
      endcase
      @(negedge clk);
      run_op(f3, a, b, 5'd10, res, rdo, wb, bz, lat);
      total++; if (res !== exp) begin bad++; $display("FAIL mulh_%0d_result got=%h want=%h", i, res, exp); end
      total++; if (lat !== 34)  begin bad++; $display("FAIL mulh_%0d_latency got=%0d want=34", i, lat); end
    end
  endtask

  task automatic test_div;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    logic [2:0] f3; logic [31:0] a, b, exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin f3 = 3'd4; a = 32'hFFFFFFF9; b = 32'd2;          exp = 32'hFFFFFFFD; end
        1: begin f3 = 3'd6; a = 32'hFFFFFFF9; b = 32'd2;          exp = 32'hFFFFFFFF; end
        2: begin f3 = 3'd5; a = 32'd100;      b = 32'd7;          exp = 32'd14; end
        3: begin f3 = 3'd7; a = 32'd100;      b = 32'd7;          exp = 32'd2; end
        4: begin f3 = 3'd4; a = 32'd7;        b = 32'hFFFFFFFE;   exp = 32'hFFFFFFFD; end
        default: begin f3 = 3'd6; a = 32'd7;  b = 32'hFFFFFFFE;   exp = 32'd1; end
      endcase
      @(negedge clk);
      run_op(f3, a, b, 5'd11, res, rdo, wb, bz, lat);
      total++; if (res !== exp) begin bad++; $display("FAIL div_%0d_result got=%h want=%h", i, res, exp); end
      total++; if (lat !== 34)  begin bad++; $display("FAIL div_%0d_latency got=%0d want=34", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    logic [2:0] f3; logic [31:0] a, b, exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin f3 = 3'd4; a = 32'd9;        b = 32'd0;        exp = 32'hFFFFFFFF; end
        1: begin f3 = 3'd7; a = 32'd9;        b = 32'd0;        exp = 32'd9; end
        2: begin f3 = 3'd4; a = 32'h80000000; b = 32'hFFFFFFFF; exp = 32'h80000000; end
        3: begin f3 = 3'd6; a = 32'h80000000; b = 32'hFFFFFFFF; exp = 32'd0; end
        4: begin f3 = 3'd3; a = 32'd0;        b = 32'd5;        exp = 32'd0; end
        default: begin f3 = 3'd0; a = 32'd0;  b = 32'h1234;     exp = 32'd0; end
      endcase
      @(negedge clk);
      run_op(f3, a, b, 5'd12, res, rdo, wb, bz, lat);
      total++; if (res !== exp)     begin bad++; $display("FAIL special_%0d_result got=%h want=%h", i, res, exp); end
      total++; if (lat !== SPEC_LAT) begin bad++; $display("FAIL special_%0d_latency got=%0d want=%0d", i, lat, SPEC_LAT); end
    end
  endtask

  task automatic test_rd_zero;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    @(negedge clk);
    run_op(3'd0, 32'd2, 32'd3, 5'd0, res, rdo, wb, bz, lat);
    total++; if (lat !== 34)     begin bad++; $display("FAIL rd0_done got_lat=%0d want=34", lat); end
    total++; if (wb !== 1'b0)    begin bad++; $display("FAIL rd0_wb_en got=%b want=0", wb); end
    total++; if (res !== 32'd6)  begin bad++; $display("FAIL rd0_result got=%h want=6", res); end
    total++; if (rdo !== 5'd0)   begin bad++; $display("FAIL rd0_rd_out got=%0d want=0", rdo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; logic [4:0] rdo; logic wb, bz; int lat;
    @(negedge clk);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, res, rdo, wb, bz, lat);
    total++; if (res !== 32'hFFFFFFFE) begin bad++; $display("FAIL b2b_first_result got=%h want=fffffffe", res); end
    // issued during the done cycle of the previous op
    run_op(3'd5, 32'd100, 32'd7, 5'd2, res, rdo, wb, bz, lat);
    total++; if (lat !== 34)    begin bad++; $display("FAIL b2b_second_latency got=%0d want=34", lat); end
    total++; if (res !== 32'd14) begin bad++; $display("FAIL b2b_second_result got=%h want=e", res); end
    total++; if (rdo !== 5'd2)  begin bad++; $display("FAIL b2b_second_rd_out got=%0d want=2", rdo); end
  endtask

  task automatic test_busy_start;
    int e; int lat;
    @(negedge clk);
    bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd7; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;   // E0
    repeat (4) @(posedge clk);              // E1..E4
    #1;
    bus.funct3 = 3'd3; bus.op_a = 32'd100; bus.op_b = 32'd100; bus.rd_in = 5'd9; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;   // E5, ignored
    e = 5; lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1; e++;
      if (bus.done) begin lat = e; break; end
    end
    $display("op busy-start ignored -> result=%h rd_out=%0d lat=%0d", bus.result, bus.rd_out, lat);
    total++; if (lat !== 34)            begin bad++; $display("FAIL busy_start_latency got=%0d want=34", lat); end
    total++; if (bus.result !== 32'd12) begin bad++; $display("FAIL busy_start_result got=%h want=c", bus.result); end
    total++; if (bus.rd_out !== 5'd7)   begin bad++; $display("FAIL busy_start_rd_out got=%0d want=7", bus.rd_out); end
  endtask

  task automatic test_flush;
    logic [31:0] prev; logic seen;
    @(negedge clk);
    @(negedge clk);
    prev = bus.result;
    bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd3; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;   // E0
    repeat (11) @(posedge clk);             // now in CALC cycle 10
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b want=1", bus.busy); end
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%b want=0", bus.busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    total++; if (seen !== 1'b0)       begin bad++; $display("FAIL flush_no_done got=%b want=0", seen); end
    total++; if (bus.result !== prev) begin bad++; $display("FAIL flush_result_kept got=%h want=%h", bus.result, prev); end
    // flush and start together in IDLE: start dropped
    bus.funct3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd_in = 5'd4;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start_dropped got=%b want=0", bus.busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_start_no_done got=%b want=0", seen); end
    $display("flush scenario done result=%h", bus.result);
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    bus.funct3 = 3'd0; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.rd_in = 5'd8; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;   // E0
    repeat (21) @(posedge clk);             // CALC cycle 20
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", bus.result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", seen); end
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_rd_zero();
    test_back_to_back();
    test_busy_start();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
